display_scan_ctrl: RTL and testbench

- Time-multiplexing controller for the 4-digit seven-segment display.
- Generates the 2-bit digit select for the upstream Mux4x1 (sel), plus the matching active-low anode enables.
- Inserts a blanking guard at the start of each digit slot to suppress ghosting.
- Emits slot and frame strobes for downstream logic, e.g. a blink generator.

---
 rtl/disp_pkg.sv | 32 +++
 rtl/scan_prescaler.sv | 53 +++++
 rtl/display_scan_ctrl.sv | 117 +++++++++++
 tb/tb_display_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants, scan state encoding and anode-pattern helper for the display scanner.
// Latency: n/a (package only).
// Backpressure: n/a.
package disp_pkg;

  localparam int N_DIGITS = 4;
  localparam int SEL_W    = $clog2(N_DIGITS);

  // Anodes are active-low: all ones means every digit is dark.
  localparam logic [N_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // Anode vector for driving digit `sel`: one bit low when that digit is
  // enabled in the mask, otherwise the whole display stays dark.
  function automatic logic [N_DIGITS-1:0] an_pattern(
    input logic [SEL_W-1:0]    sel,
    input logic [N_DIGITS-1:0] digit_en
  );
    logic [N_DIGITS-1:0] an;
    an = AN_OFF;
    if (digit_en[sel]) begin
      an[sel] = 1'b0;
    end
    return an;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter for the display scanner: counts clk cycles within a digit slot.
// Latency: wrap/blank_end are combinational decodes of the registered count.
// Backpressure: none; en=0 clears the count, run=0 holds it at zero.
//
// Ports:
//   clk, rst   - clock and async active-high reset
//   en         - scan enable; low clears the counter
//   run        - high while the FSM is in a counting state (BLANK/DRIVE)
//   wrap       - count is at PRESCALE-1 (last cycle of the slot)
//   blank_end  - count is at BLANK_CYCLES-1 (last blanked cycle); never set when BLANK_CYCLES=0
module scan_prescaler #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic run,
  output logic wrap,
  output logic blank_end
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  // With no blanking there is no blank-end point; the value is unused then.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic             HAS_BLANK  = (BLANK_CYCLES > 0);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Every slot (and every restart after en drops) begins from zero, so the
  // counter only ever advances while enabled and inside a slot.
  always_comb begin
    cnt_d = '0;
    if (en && run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wrap      = run && (cnt_q == CNT_LAST);
  assign blank_end = run && HAS_BLANK && (cnt_q == BLANK_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display with blanking guard.
// Latency: all outputs registered; sel, an and ticks change together on the same edge.
// Backpressure: none; en=0 parks the scanner (display dark, sel held) until re-enabled.
//
// Ports:
//   clk, rst    - clock and async active-high reset
//   en          - scan enable; 0 freezes scanning and blanks the display
//   digit_en    - per-digit mask; bit i=0 keeps anode i off
//   sel         - current digit index for the segment mux
//   an          - active-low anode enables, matching sel
//   slot_tick   - one-cycle pulse on each sel advance
//   frame_tick  - one-cycle pulse when sel wraps 3->0
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_DIGITS-1:0] digit_en,
  output logic [SEL_W-1:0]    sel,
  output logic [N_DIGITS-1:0] an,
  output logic                slot_tick,
  output logic                frame_tick
);

  // A slot opens in BLANK unless there is no guard, in which case it drives
  // from its very first cycle.
  localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_DIGITS - 1);

  scan_state_t         state_d,      state_q;
  logic [SEL_W-1:0]    sel_d,        sel_q;
  logic [N_DIGITS-1:0] an_d,         an_q;
  logic                slot_tick_d,  slot_tick_q;
  logic                frame_tick_d, frame_tick_q;

  logic run;
  logic wrap;
  logic blank_end;

  assign run = (state_q != IDLE);

  scan_prescaler #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .run       (run),
    .wrap      (wrap),
    .blank_end (blank_end)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    an_d         = AN_OFF;
    slot_tick_d  = 1'b0;
    frame_tick_d = 1'b0;

    if (!en) begin
      // Disable wins over a coincident slot end: no tick, sel stays put.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SLOT_START;
        end
        BLANK, DRIVE: begin
          if (wrap) begin
            sel_d        = sel_q + 1'b1;
            slot_tick_d  = 1'b1;
            frame_tick_d = (sel_q == SEL_LAST);
            state_d      = SLOT_START;
          end else if ((state_q == BLANK) && blank_end) begin
            state_d = DRIVE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Anodes are derived from the next state/sel so they always line up
    // with the sel value presented on the same edge.
    if (state_d == DRIVE) begin
      an_d = an_pattern(sel_d, digit_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      an_q         <= AN_OFF;
      slot_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      an_q         <= an_d;
      slot_tick_q  <= slot_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sel        = sel_q;
  assign an         = an_q;
  assign slot_tick  = slot_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (P=8/B=2 and P=2/B=0) share stimulus.
// A position-in-slot model is compared every cycle; directed literals pin the model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_display_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] digit_en;

  logic [1:0] sel_a, sel_b;
  logic [3:0] an_a,  an_b;
  logic       st_a,  st_b;
  logic       ft_a,  ft_b;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int k        = 0;

  display_scan_ctrl #(.PRESCALE(8), .BLANK_CYCLES(2)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_en   (digit_en),
    .sel        (sel_a),
    .an         (an_a),
    .slot_tick  (st_a),
    .frame_tick (ft_a)
  );

  display_scan_ctrl #(.PRESCALE(2), .BLANK_CYCLES(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_en   (digit_en),
    .sel        (sel_b),
    .an         (an_b),
    .slot_tick  (st_b),
    .frame_tick (ft_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tot_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: whether a scan run is active, position within the slot
  // (0..P-1), and the digit index. Blank when position < B.
  int         m_pos [2];
  int         m_sel [2];
  bit         m_act [2];
  logic [3:0] m_an  [2];
  logic       m_st  [2];
  logic       m_ft  [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      int p, b, pos, s;
      bit act;
      logic st, ft;
      logic [3:0] a;
      p   = (i == 0) ? 8 : 2;
      b   = (i == 0) ? 2 : 0;
      pos = m_pos[i];
      s   = m_sel[i];
      act = m_act[i];
      st  = 1'b0;
      ft  = 1'b0;
      if (rst) begin
        pos = 0; s = 0; act = 1'b0;
      end else if (!en) begin
        pos = 0; act = 1'b0;
      end else if (!act) begin
        act = 1'b1; pos = 0;
      end else begin
        pos = pos + 1;
        if (pos == p) begin
          pos = 0;
          st  = 1'b1;
          ft  = (s == 3);
          s   = (s + 1) % 4;
        end
      end
      a = 4'hF;
      if (act && (pos >= b) && digit_en[s]) a[s] = 1'b0;
      m_pos[i] <= pos;
      m_sel[i] <= s;
      m_act[i] <= act;
      m_an[i]  <= a;
      m_st[i]  <= st;
      m_ft[i]  <= ft;
    end
  end

  always @(negedge clk) begin
    chk("a_sel", {2'b00, sel_a}, 4'(m_sel[0]));
    chk("a_an",  an_a, m_an[0]);
    chk("a_slot_tick", {3'b000, st_a}, {3'b000, m_st[0]});
    chk("a_frame_tick", {3'b000, ft_a}, {3'b000, m_ft[0]});
    chk("b_sel", {2'b00, sel_b}, 4'(m_sel[1]));
    chk("b_an",  an_b, m_an[1]);
    chk("b_slot_tick", {3'b000, st_b}, {3'b000, m_st[1]});
    chk("b_frame_tick", {3'b000, ft_b}, {3'b000, m_ft[1]});
  end

  // ---------------- directed stimulus ----------------
  task automatic step_to(input int t);
    while (k < t) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    digit_en = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", {2'b00, sel_a}, 4'd0);
    chk("rst_an", an_a, 4'b1111);
    chk("rst_ticks", {2'b00, st_a, ft_a}, 4'd0);
    rst = 1'b0;
    en  = 1'b1;
    k   = 0;

    // Test 1 / 6: basic scan on both configs
    step_to(1);
    chk("t1_blank0_an", an_a, 4'b1111);
    chk("t1_blank0_sel", {2'b00, sel_a}, 4'd0);
    chk("t6_e1_an", an_b, 4'b1110);
    step_to(2);
    chk("t6_e2_an", an_b, 4'b1110);
    step_to(3);
    chk("t1_drive0_an", an_a, 4'b1110);
    chk("t6_e3_an", an_b, 4'b1101);
    chk("t6_e3_tick", {3'b000, st_b}, 4'd1);
    step_to(4);
    chk("t6_e4_an", an_b, 4'b1101);
    chk("t6_e4_tick", {3'b000, st_b}, 4'd0);
    step_to(5);
    chk("t6_e5_an", an_b, 4'b1011);
    chk("t6_e5_sel", {2'b00, sel_b}, 4'd2);
    step_to(8);
    chk("t1_last0_an", an_a, 4'b1110);
    chk("t1_last0_tick", {3'b000, st_a}, 4'd0);
    step_to(9);
    chk("t1_adv1_sel", {2'b00, sel_a}, 4'd1);
    chk("t1_adv1_tick", {2'b00, st_a, ft_a}, 4'b0010);
    chk("t1_adv1_an", an_a, 4'b1111);
    step_to(11);
    chk("t1_drive1_an", an_a, 4'b1101);
    step_to(25);
    chk("t1_adv3_sel", {2'b00, sel_a}, 4'd3);
    step_to(27);
    chk("t1_drive3_an", an_a, 4'b0111);
    step_to(33);
    chk("t1_wrap_sel", {2'b00, sel_a}, 4'd0);
    chk("t1_wrap_ticks", {2'b00, st_a, ft_a}, 4'b0011);

    // Test 2: digit 2 masked off
    digit_en = 4'b1011;
    step_to(51);
    chk("t2_sel2", {2'b00, sel_a}, 4'd2);
    chk("t2_sel2_an", an_a, 4'b1111);
    step_to(56);
    chk("t2_sel2_end_an", an_a, 4'b1111);
    step_to(57);
    chk("t2_adv3", {2'b00, sel_a}, 4'd3);
    chk("t2_adv3_tick", {3'b000, st_a}, 4'd1);
    step_to(59);
    chk("t2_drive3_an", an_a, 4'b0111);
    digit_en = 4'b1111;

    // Test 3: en dropped mid-DRIVE at sel=1, cnt=5
    step_to(78);
    chk("t3_pre_sel", {2'b00, sel_a}, 4'd1);
    chk("t3_pre_an", an_a, 4'b1101);
    en = 1'b0;
    step_to(79);
    chk("t3_off_an", an_a, 4'b1111);
    chk("t3_off_sel", {2'b00, sel_a}, 4'd1);
    chk("t3_off_tick", {3'b000, st_a}, 4'd0);
    step_to(88);
    chk("t3_idle_sel", {2'b00, sel_a}, 4'd1);
    en = 1'b1;
    step_to(89);
    chk("t3_re_blank", an_a, 4'b1111);
    step_to(91);
    chk("t3_re_drive", an_a, 4'b1101);
    step_to(96);
    chk("t3_re_last", an_a, 4'b1101);
    chk("t3_re_last_tick", {3'b000, st_a}, 4'd0);
    step_to(97);
    chk("t3_re_adv", {2'b00, sel_a}, 4'd2);
    chk("t3_re_adv_tick", {3'b000, st_a}, 4'd1);

    // Test 4: en dropped exactly at cnt=7 of sel=3
    step_to(112);
    chk("t4_pre_an", an_a, 4'b0111);
    en = 1'b0;
    step_to(113);
    chk("t4_off_sel", {2'b00, sel_a}, 4'd3);
    chk("t4_off_ticks", {2'b00, st_a, ft_a}, 4'd0);
    chk("t4_off_an", an_a, 4'b1111);
    step_to(115);
    chk("t4_hold_sel", {2'b00, sel_a}, 4'd3);
    en = 1'b1;

    // Test 5: async reset mid-slot at sel=3
    step_to(119);
    chk("t5_pre_sel", {2'b00, sel_a}, 4'd3);
    chk("t5_pre_an", an_a, 4'b0111);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_sel", {2'b00, sel_a}, 4'd0);
    chk("t5_async_an", an_a, 4'b1111);
    chk("t5_async_ticks", {2'b00, st_a, ft_a}, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    k   = 0;
    step_to(1);
    chk("t5_first_an", an_a, 4'b1111);
    chk("t5_b_first_an", an_b, 4'b1110);
    step_to(3);
    chk("t5_b_adv", {2'b00, sel_b}, 4'd1);
    step_to(8);
    chk("t5_no_tick_yet", {3'b000, st_a}, 4'd0);
    step_to(9);
    chk("t5_first_tick", {3'b000, st_a}, 4'd1);
    chk("t5_first_sel", {2'b00, sel_a}, 4'd1);

    step_to(40);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
